// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: branch/jump resolution, trap entry, HALT/resume
// handling and a saturating count of taken redirects.
module pc_seq_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  imm,
    input  logic             trap_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             pc_sel,
    output logic             misalign,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_taken;
    logic             w_br_taken;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [XLEN-1:0]  w_target;
    logic             w_run;

    always_comb begin
        w_br_taken = 1'b0;
        unique case (funct3)
            3'b000:  w_br_taken = (rs1_val == rs2_val);
            3'b001:  w_br_taken = (rs1_val != rs2_val);
            3'b100:  w_br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  w_br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  w_br_taken = (rs1_val <  rs2_val);
            3'b111:  w_br_taken = (rs1_val >= rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_taken    = 1'b0;
        w_jalr_sum = rs1_val + imm;
        w_target   = r_pc + imm;
        unique case (opcode)
            OP_BRANCH: w_taken = w_br_taken;
            OP_JAL:    w_taken = 1'b1;
            OP_JALR: begin
                w_taken  = 1'b1;
                w_target = w_jalr_sum & ~XLEN'(1);
            end
            default:   w_taken = 1'b0;
        endcase
    end

    // Redirect qualifiers are gated by RUN so BOOT/HALT never report a redirect.
    assign w_run        = (r_state == ST_RUN);
    assign misalign     = w_run && w_taken && w_target[1];
    assign pc_sel       = w_run && w_taken && !w_target[1];
    assign pc_plus4     = r_pc + XLEN'(4);
    assign pc           = r_pc;
    assign state        = r_state;
    assign redirect_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_state <= ST_BOOT;
            r_cnt   <= '0;
        end else begin
            if (pc_sel && !stall && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                ST_BOOT: begin
                    r_pc    <= RESET_VECTOR;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (trap_req) begin
                        r_pc    <= TRAP_VECTOR;
                        r_state <= ST_HALT;
                    end else if (stall) begin
                        r_pc    <= r_pc;
                    end else if (misalign) begin
                        r_pc    <= TRAP_VECTOR;
                        r_state <= ST_HALT;
                    end else if (pc_sel) begin
                        r_pc    <= w_target;
                    end else begin
                        r_pc    <= pc_plus4;
                    end
                end
                ST_HALT: begin
                    if (resume)
                        r_state <= ST_RUN;
                end
                default: begin
                    r_pc    <= RESET_VECTOR;
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: expected pc/state/count pushed per cycle
// of stimulus, popped and compared one clock later.
module tb_pc_seq_ctrl;

    localparam logic [6:0] OP_ALU  = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n, stall, trap_req, resume;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] pc, pc_plus4, pc2, pc_plus4_2;
    logic        pc_sel, misalign, pc_sel2, misalign2;
    logic [1:0]  state, state2;
    logic [15:0] redirect_cnt;
    logic [1:0]  redirect_cnt2;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .trap_req(trap_req),
        .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .pc_sel(pc_sel),
        .misalign(misalign), .state(state), .redirect_cnt(redirect_cnt)
    );

    pc_seq_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .trap_req(trap_req),
        .resume(resume), .pc(pc2), .pc_plus4(pc_plus4_2), .pc_sel(pc_sel2),
        .misalign(misalign2), .state(state2), .redirect_cnt(redirect_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic st, input logic tr, input logic rs);
        opcode = op; funct3 = f3; rs1_val = a; rs2_val = b; imm = im;
        stall = st; trap_req = tr; resume = rs;
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [1:0] s, input logic [15:0] c);
        exp_t e;
        e.pc = p; e.st = s; e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pc"},    pc,                  e.pc);
            chk({tag, "_state"}, {30'd0, state},      {30'd0, e.st});
            chk({tag, "_cnt"},   {16'd0, redirect_cnt}, {16'd0, e.cnt});
            chk({tag, "_pc4"},   pc_plus4,            e.pc + 32'd4);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        push(32'h0, S_BOOT, 16'd0); tick("rst");
        chk("rst_c2_cnt", {30'd0, redirect_cnt2}, 32'd0);

        // BOOT ignores stall/trap; redirect flags stay low.
        rst_n = 1'b1;
        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'd8, 1'b1, 1'b1, 1'b0);
        chk("boot_pcsel", {31'd0, pc_sel}, 32'd0);
        chk("boot_mis",   {31'd0, misalign}, 32'd0);
        push(32'h0, S_RUN, 16'd0); tick("boot");

        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("seq_pcsel", {31'd0, pc_sel}, 32'd0);
        push(32'h4, S_RUN, 16'd0); tick("seq4");
        push(32'h8, S_RUN, 16'd0); tick("seq8");
        push(32'hC, S_RUN, 16'd0); tick("seq12");

        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h34, 1'b0, 1'b0, 1'b0);
        chk("jal_pcsel", {31'd0, pc_sel}, 32'd1);
        push(32'h40, S_RUN, 16'd1); tick("jal40");

        drive(OP_BR, 3'b000, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 1'b0);
        chk("beq_pcsel", {31'd0, pc_sel}, 32'd1);
        push(32'h60, S_RUN, 16'd2); tick("beq");

        drive(OP_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b0, 1'b0);
        chk("blt_pcsel", {31'd0, pc_sel}, 32'd1);
        push(32'h70, S_RUN, 16'd3); tick("blt");

        drive(OP_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b0, 1'b0);
        chk("bltu_pcsel", {31'd0, pc_sel}, 32'd0);
        push(32'h74, S_RUN, 16'd3); tick("bltu");

        drive(OP_BR, 3'b001, 32'd5, 32'd5, 32'h10, 1'b0, 1'b0, 1'b0);
        push(32'h78, S_RUN, 16'd3); tick("bne");

        drive(OP_BR, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h8, 1'b0, 1'b0, 1'b0);
        push(32'h80, S_RUN, 16'd4); tick("bge");

        drive(OP_BR, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h8, 1'b0, 1'b0, 1'b0);
        push(32'h84, S_RUN, 16'd4); tick("bgeu");

        drive(OP_BR, 3'b010, 32'd7, 32'd7, 32'h8, 1'b0, 1'b0, 1'b0);
        push(32'h88, S_RUN, 16'd4); tick("f3_010");

        drive(OP_JALR, 3'b000, 32'h1003, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("jalr_mis",   {31'd0, misalign}, 32'd1);
        chk("jalr_pcsel", {31'd0, pc_sel},   32'd0);
        push(32'h100, S_HALT, 16'd4); tick("jalr_trap");

        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b0, 1'b1, 1'b0);
        chk("halt_pcsel", {31'd0, pc_sel}, 32'd0);
        push(32'h100, S_HALT, 16'd4); tick("halt_trap");

        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        push(32'h100, S_RUN, 16'd4); tick("resume");
        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        push(32'h104, S_RUN, 16'd4); tick("resume_adv");

        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b1, 1'b1, 1'b0);
        push(32'h100, S_HALT, 16'd4); tick("stall_trap");
        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        push(32'h100, S_RUN, 16'd4); tick("resume2");
        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        push(32'h104, S_RUN, 16'd4); tick("resume2_adv");

        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b1, 1'b0, 1'b0);
        push(32'h104, S_RUN, 16'd4); tick("stall_jal");
        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b0);
        push(32'h144, S_RUN, 16'd5); tick("jal_go");

        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'hFFFF_FEB8, 1'b0, 1'b0, 1'b0);
        push(32'hFFFF_FFFC, S_RUN, 16'd6); tick("jal_top");
        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc4", pc_plus4, 32'h0);
        push(32'h0, S_RUN, 16'd6); tick("wrap");

        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        push(32'h100, S_HALT, 16'd6); tick("trap_run");
        rst_n = 1'b0;
        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b1);
        push(32'h0, S_BOOT, 16'd0); tick("rst_halt");

        rst_n = 1'b1;
        drive(OP_ALU, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        push(32'h0, S_RUN, 16'd0); tick("boot2");
        drive(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h8, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            push(32'(8 * i), S_RUN, 16'(i)); tick("sat_jal");
        end
        chk("c2_sat", {30'd0, redirect_cnt2}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
